// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: packet layout, arbitration modes and
// the CPU configuration record that sizes the number of writeback groups.
package writeback_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int ID_W = 4;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic            valid;
        id_t             id;
        logic [XLEN-1:0] data;
    } wb_packet_t;

    typedef enum logic {
        WB_ARB_FIXED,
        WB_ARB_RR
    } wb_arb_mode_t;

    typedef struct packed {
        int NUM_WB_GROUPS;
    } cpu_config_t;

    localparam cpu_config_t EXAMPLE_CONFIG = '{NUM_WB_GROUPS: 2};

    // Encoded select width; a single-unit group still gets one bit.
    function automatic int sel_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Per-unit writeback handshake between an execution unit and the arbiter.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    // done is the valid, ack the ready: a writeback transfers on a clk edge where
    // both are high; the unit holds done/id/rd stable until it sees that edge.
    logic            done;
    id_t             id;
    logic [XLEN-1:0] rd;
    logic            ack;

    modport wb   (input done, id, rd, output ack);
    modport unit (output done, id, rd, input ack);
endinterface

// File: rtl/writeback_arbiter_group.sv
// One writeback group's arbiter: picks a single done unit per cycle using
// fixed priority (with optional aging) or round-robin, and reports it one-hot and encoded.
module wb_group_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int           WIDTH    = 4,
    parameter wb_arb_mode_t MODE     = WB_ARB_FIXED,
    parameter int           MAX_WAIT = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              done,
    output logic [WIDTH-1:0]              grant,
    output logic [sel_width(WIDTH)-1:0]   sel,
    output logic                          valid
);
    localparam int SW = sel_width(WIDTH);

    logic [SW-1:0] pick;

    // Grants are held off while reset is asserted, even though done may be high.
    assign valid = rst_n && (|done);
    assign sel   = pick;

    always_comb begin
        grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            grant[i] = valid && (pick == SW'(i));
        end
    end

    if (WIDTH == 1) begin : g_single
        logic unused_clk;
        assign unused_clk = clk;
        assign pick       = '0;
    end else if (MODE == WB_ARB_RR) begin : g_rr
        logic [SW-1:0] rr_ptr;
        logic [SW-1:0] rr_pick;

        // Lowest done index at or above the pointer, else wrap to the lowest done index.
        always_comb begin
            rr_pick = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (done[i]) rr_pick = SW'(i);
            end
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (done[i] && (SW'(i) >= rr_ptr)) rr_pick = SW'(i);
            end
        end

        assign pick = rr_pick;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr <= '0;
            end else if (valid) begin
                rr_ptr <= (rr_pick == SW'(WIDTH - 1)) ? '0 : rr_pick + SW'(1);
            end
        end
    end else begin : g_fixed
        logic [SW-1:0] low_pick;

        always_comb begin
            low_pick = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (done[i]) low_pick = SW'(i);
            end
        end

        if (MAX_WAIT > 0) begin : g_age
            localparam logic [7:0] MAX8 = 8'(MAX_WAIT);
            logic [7:0]    wait_cnt [WIDTH];
            logic [SW-1:0] age_pick;
            logic          any_aged;

            always_comb begin
                age_pick = '0;
                any_aged = 1'b0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (done[i] && (wait_cnt[i] == MAX8)) begin
                        age_pick = SW'(i);
                        any_aged = 1'b1;
                    end
                end
            end

            assign pick = any_aged ? age_pick : low_pick;

            // A saturated loser keeps its count so it wins the following cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < WIDTH; i++) wait_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (!done[i] || grant[i]) begin
                            wait_cnt[i] <= '0;
                        end else if (wait_cnt[i] != MAX8) begin
                            wait_cnt[i] <= wait_cnt[i] + 8'd1;
                        end
                    end
                end
            end
        end else begin : g_plain
            logic unused_clk;
            assign unused_clk = clk;
            assign pick       = low_pick;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter top: unpacks the unit interfaces, arbitrates each group,
// muxes id/data into the group packet, optionally registers it, and drives the snoop copy.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter cpu_config_t  CONFIG          = EXAMPLE_CONFIG,
    parameter int           NUM_WB_UNITS    = 5,
    parameter int           NUM_UNITS [CONFIG.NUM_WB_GROUPS] = '{1, 4},
    parameter wb_arb_mode_t ARB_MODE  [CONFIG.NUM_WB_GROUPS] = '{WB_ARB_FIXED, WB_ARB_FIXED},
    parameter int           MAX_WAIT        = 0,
    parameter bit           REGISTER_OUTPUT = 1'b0,
    parameter int           SNOOP_GROUP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_arbiter_if.wb      unit_wb [NUM_WB_UNITS],
    output wb_packet_t           wb_packet [CONFIG.NUM_WB_GROUPS],
    output wb_packet_t           wb_snoop
);
    localparam int NUM_GROUPS = CONFIG.NUM_WB_GROUPS;

    // Units are numbered globally with groups laid out back to back.
    function automatic int group_base(int g);
        int s = 0;
        for (int i = 0; i < g; i++) s += NUM_UNITS[i];
        return s;
    endfunction

    logic            unit_done [NUM_WB_UNITS];
    id_t             unit_id   [NUM_WB_UNITS];
    logic [XLEN-1:0] unit_rd   [NUM_WB_UNITS];
    logic            unit_ack  [NUM_WB_UNITS];

    for (genvar i = 0; i < NUM_WB_UNITS; i++) begin : g_unpack
        assign unit_done[i]   = unit_wb[i].done;
        assign unit_id[i]     = unit_wb[i].id;
        assign unit_rd[i]     = unit_wb[i].rd;
        assign unit_wb[i].ack = unit_ack[i];
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        localparam int W    = NUM_UNITS[g];
        localparam int BASE = group_base(g);
        localparam int SW   = sel_width(W);

        logic [W-1:0]  done_v;
        logic [W-1:0]  grant_v;
        logic [SW-1:0] sel;
        logic          valid;
        wb_packet_t    pkt;

        for (genvar u = 0; u < W; u++) begin : g_unit
            assign done_v[u]        = unit_done[BASE + u];
            assign unit_ack[BASE + u] = grant_v[u];
        end

        wb_group_arbiter #(
            .WIDTH    (W),
            .MODE     (ARB_MODE[g]),
            .MAX_WAIT (MAX_WAIT)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .done  (done_v),
            .grant (grant_v),
            .sel   (sel),
            .valid (valid)
        );

        // Without a grant the packet is all zero rather than leaking a unit's fields.
        always_comb begin
            pkt       = '0;
            pkt.valid = valid;
            for (int u = 0; u < W; u++) begin
                if (valid && (sel == SW'(u))) begin
                    pkt.id   = unit_id[BASE + u];
                    pkt.data = unit_rd[BASE + u];
                end
            end
        end

        if (REGISTER_OUTPUT) begin : g_reg
            wb_packet_t pkt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pkt_q <= '0;
                else        pkt_q <= pkt;
            end
            assign wb_packet[g] = pkt_q;
        end else begin : g_comb
            assign wb_packet[g] = pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_snoop <= '0;
        else        wb_snoop <= wb_packet[SNOOP_GROUP];
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: four configurations share one set of unit drivers,
// each scenario task checks the instance configured for it against hand-computed values.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int NU = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            done_v [NU];
    id_t             id_v   [NU];
    logic [XLEN-1:0] rd_v   [NU];
    logic fix_ack [NU], rr_ack [NU], age_ack [NU], reg_ack [NU];
    wb_packet_t fix_pkt [2], rr_pkt [2], age_pkt [2], reg_pkt [2];
    wb_packet_t fix_snp, rr_snp, age_snp, reg_snp;

    int checks = 0;
    int errors = 0;

    writeback_arbiter_if fix_if [NU] ();
    writeback_arbiter_if rr_if  [NU] ();
    writeback_arbiter_if age_if [NU] ();
    writeback_arbiter_if reg_if [NU] ();

    for (genvar i = 0; i < NU; i++) begin : g_drv
        assign fix_if[i].done = done_v[i];
        assign fix_if[i].id   = id_v[i];
        assign fix_if[i].rd   = rd_v[i];
        assign fix_ack[i]     = fix_if[i].ack;
        assign rr_if[i].done  = done_v[i];
        assign rr_if[i].id    = id_v[i];
        assign rr_if[i].rd    = rd_v[i];
        assign rr_ack[i]      = rr_if[i].ack;
        assign age_if[i].done = done_v[i];
        assign age_if[i].id   = id_v[i];
        assign age_if[i].rd   = rd_v[i];
        assign age_ack[i]     = age_if[i].ack;
        assign reg_if[i].done = done_v[i];
        assign reg_if[i].id   = id_v[i];
        assign reg_if[i].rd   = rd_v[i];
        assign reg_ack[i]     = reg_if[i].ack;
    end

    writeback_arbiter dut_fix (
        .clk(clk), .rst_n(rst_n), .unit_wb(fix_if), .wb_packet(fix_pkt), .wb_snoop(fix_snp)
    );
    writeback_arbiter #(.ARB_MODE('{WB_ARB_FIXED, WB_ARB_RR})) dut_rr (
        .clk(clk), .rst_n(rst_n), .unit_wb(rr_if), .wb_packet(rr_pkt), .wb_snoop(rr_snp)
    );
    writeback_arbiter #(.MAX_WAIT(3)) dut_age (
        .clk(clk), .rst_n(rst_n), .unit_wb(age_if), .wb_packet(age_pkt), .wb_snoop(age_snp)
    );
    writeback_arbiter #(.REGISTER_OUTPUT(1'b1)) dut_reg (
        .clk(clk), .rst_n(rst_n), .unit_wb(reg_if), .wb_packet(reg_pkt), .wb_snoop(reg_snp)
    );

    task automatic clear_units();
        for (int i = 0; i < NU; i++) begin
            done_v[i] = 1'b0;
            id_v[i]   = '0;
            rd_v[i]   = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_units();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_units();
        for (int i = 0; i < NU; i++) begin
            done_v[i] = 1'b1;
            id_v[i]   = id_t'(i + 1);
            rd_v[i]   = 32'h5000_0000 + 32'(i);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NU; i++) begin
            checks++;
            if ({fix_ack[i], rr_ack[i], age_ack[i], reg_ack[i]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ack[%0d]: got %b%b%b%b expected 0000", i,
                         fix_ack[i], rr_ack[i], age_ack[i], reg_ack[i]);
            end
        end
        checks++;
        if (reg_pkt[1] !== '0 || reg_pkt[0] !== '0) begin
            errors++;
            $display("FAIL reset_reg_pkt: got %h/%h expected 0", reg_pkt[0], reg_pkt[1]);
        end
        checks++;
        if (fix_pkt[1] !== '0) begin
            errors++;
            $display("FAIL reset_comb_pkt: got %h expected 0", fix_pkt[1]);
        end
        next_cycle();
        checks++;
        if (fix_snp !== '0 || reg_snp !== '0 || rr_snp !== '0) begin
            errors++;
            $display("FAIL reset_snoop: got %h/%h/%h expected 0", fix_snp, reg_snp, rr_snp);
        end
        apply_reset();
    endtask

    task automatic test_fixed();
        wb_packet_t exp_p;
        apply_reset();
        done_v[1] = 1'b1; id_v[1] = 4'd1; rd_v[1] = 32'h1111_0001;
        done_v[3] = 1'b1; id_v[3] = 4'd3; rd_v[3] = 32'h3333_0003;
        @(negedge clk);
        checks++;
        if ({fix_ack[1], fix_ack[3]} !== 2'b10) begin
            errors++;
            $display("FAIL fixed_ack_c0: got %b%b expected 10", fix_ack[1], fix_ack[3]);
        end
        exp_p = '{valid: 1'b1, id: 4'd1, data: 32'h1111_0001};
        checks++;
        if (fix_pkt[1] !== exp_p) begin
            errors++;
            $display("FAIL fixed_pkt_c0: got %h expected %h", fix_pkt[1], exp_p);
        end
        next_cycle();
        done_v[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({fix_ack[1], fix_ack[3]} !== 2'b01) begin
            errors++;
            $display("FAIL fixed_ack_c1: got %b%b expected 01", fix_ack[1], fix_ack[3]);
        end
        checks++;
        if (fix_snp !== exp_p) begin
            errors++;
            $display("FAIL fixed_snoop_c1: got %h expected %h", fix_snp, exp_p);
        end
        exp_p = '{valid: 1'b1, id: 4'd3, data: 32'h3333_0003};
        checks++;
        if (fix_pkt[1] !== exp_p) begin
            errors++;
            $display("FAIL fixed_pkt_c1: got %h expected %h", fix_pkt[1], exp_p);
        end
        next_cycle();
        done_v[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (fix_pkt[1] !== '0) begin
            errors++;
            $display("FAIL fixed_idle_pkt: got %h expected 0", fix_pkt[1]);
        end
        checks++;
        if (fix_snp !== exp_p) begin
            errors++;
            $display("FAIL fixed_snoop_c2: got %h expected %h", fix_snp, exp_p);
        end
        next_cycle();
    endtask

    // Leaves the round-robin pointer at 2 for test_reset_mid.
    task automatic test_round_robin();
        int         seq [6] = '{0, 1, 2, 3, 0, 1};
        wb_packet_t exp_p;
        logic [3:0] exp_ack;
        apply_reset();
        for (int u = 1; u <= 4; u++) begin
            done_v[u] = 1'b1;
            id_v[u]   = id_t'(u);
            rd_v[u]   = 32'hA000_0000 + 32'(u);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_p   = '{valid: 1'b1, id: id_t'(seq[c] + 1), data: 32'hA000_0000 + 32'(seq[c] + 1)};
            exp_ack = 4'b0001 << seq[c];
            checks++;
            if (rr_pkt[1] !== exp_p) begin
                errors++;
                $display("FAIL rr_pkt_c%0d: got %h expected %h", c, rr_pkt[1], exp_p);
            end
            checks++;
            if ({rr_ack[4], rr_ack[3], rr_ack[2], rr_ack[1]} !== exp_ack) begin
                errors++;
                $display("FAIL rr_ack_c%0d: got %b%b%b%b expected %b", c,
                         rr_ack[4], rr_ack[3], rr_ack[2], rr_ack[1], exp_ack);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        wb_packet_t exp_p;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rr_pkt[1] !== '0 || rr_snp !== '0) begin
            errors++;
            $display("FAIL mid_reset_out: got %h/%h expected 0/0", rr_pkt[1], rr_snp);
        end
        checks++;
        if ({rr_ack[4], rr_ack[3], rr_ack[2], rr_ack[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_ack: got %b%b%b%b expected 0000",
                     rr_ack[4], rr_ack[3], rr_ack[2], rr_ack[1]);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        exp_p = '{valid: 1'b1, id: 4'd1, data: 32'hA000_0001};
        checks++;
        if (rr_pkt[1] !== exp_p) begin
            errors++;
            $display("FAIL mid_reset_first_grant: got %h expected %h", rr_pkt[1], exp_p);
        end
        checks++;
        if (rr_snp !== '0) begin
            errors++;
            $display("FAIL mid_reset_snoop: got %h expected 0", rr_snp);
        end
        next_cycle();
    endtask

    task automatic test_aging();
        int         exp_w [5] = '{1, 1, 1, 4, 1};
        wb_packet_t exp_p;
        apply_reset();
        done_v[1] = 1'b1; id_v[1] = 4'd1; rd_v[1] = 32'h0000_0100;
        done_v[4] = 1'b1; id_v[4] = 4'd4; rd_v[4] = 32'h0000_0400;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_p = (exp_w[c] == 4) ? '{valid: 1'b1, id: 4'd4, data: 32'h0000_0400}
                                    : '{valid: 1'b1, id: 4'd1, data: 32'h0000_0100};
            checks++;
            if (age_pkt[1] !== exp_p) begin
                errors++;
                $display("FAIL aging_pkt_c%0d: got %h expected %h", c, age_pkt[1], exp_p);
            end
            checks++;
            if ({age_ack[4], age_ack[1]} !== ((exp_w[c] == 4) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL aging_ack_c%0d: got %b%b expected winner %0d", c,
                         age_ack[4], age_ack[1], exp_w[c]);
            end
            next_cycle();
            if (exp_w[c] == 4) done_v[4] = 1'b0;
        end
        done_v[1] = 1'b0;
    endtask

    task automatic test_register_output();
        wb_packet_t exp_p;
        apply_reset();
        exp_p = '{valid: 1'b1, id: 4'd5, data: 32'hDEAD_BEEF};
        done_v[2] = 1'b1; id_v[2] = 4'd5; rd_v[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (reg_ack[2] !== 1'b1 || reg_pkt[1] !== '0) begin
            errors++;
            $display("FAIL regout_n: got ack %b pkt %h expected ack 1 pkt 0", reg_ack[2], reg_pkt[1]);
        end
        next_cycle();
        done_v[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_pkt[1] !== exp_p || reg_snp !== '0) begin
            errors++;
            $display("FAIL regout_n1: got pkt %h snoop %h expected pkt %h snoop 0",
                     reg_pkt[1], reg_snp, exp_p);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (reg_pkt[1] !== '0 || reg_snp !== exp_p) begin
            errors++;
            $display("FAIL regout_n2: got pkt %h snoop %h expected pkt 0 snoop %h",
                     reg_pkt[1], reg_snp, exp_p);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        wb_packet_t exp_a, exp_b;
        apply_reset();
        exp_a = '{valid: 1'b1, id: 4'd6, data: 32'h0000_0006};
        exp_b = '{valid: 1'b1, id: 4'd7, data: 32'h0000_0007};
        done_v[1] = 1'b1; id_v[1] = 4'd6; rd_v[1] = 32'h0000_0006;
        done_v[2] = 1'b1; id_v[2] = 4'd7; rd_v[2] = 32'h0000_0007;
        next_cycle();
        done_v[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_pkt[1] !== exp_a || reg_ack[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got pkt %h ack %b expected pkt %h ack 1",
                     reg_pkt[1], reg_ack[2], exp_a);
        end
        next_cycle();
        done_v[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_pkt[1] !== exp_b) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", reg_pkt[1], exp_b);
        end
        next_cycle();
    endtask

    task automatic test_single_unit();
        wb_packet_t exp_p;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            done_v[0] = 1'b1;
            id_v[0]   = id_t'(c + 8);
            rd_v[0]   = 32'hC0DE_0000 + 32'(c * 17);
            exp_p     = '{valid: 1'b1, id: id_t'(c + 8), data: 32'hC0DE_0000 + 32'(c * 17)};
            @(negedge clk);
            checks++;
            if (fix_ack[0] !== 1'b1 || fix_pkt[0] !== exp_p) begin
                errors++;
                $display("FAIL single_c%0d: got ack %b pkt %h expected ack 1 pkt %h",
                         c, fix_ack[0], fix_pkt[0], exp_p);
            end
            next_cycle();
        end
        done_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (fix_ack[0] !== 1'b0 || fix_pkt[0] !== '0) begin
            errors++;
            $display("FAIL single_idle: got ack %b pkt %h expected ack 0 pkt 0", fix_ack[0], fix_pkt[0]);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_reset_mid();
        test_aging();
        test_register_output();
        test_back_to_back();
        test_single_unit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
